// File: rtl/nios_ii_pll_ctrl_pkg.sv
// Shared encodings and widths for the NIOS II PLL reset sequencer.
// State values are visible on the state port, so they are fixed here.
package nios_ii_pll_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int LLC_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nios_ii_pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock flag into the reference clock domain.
module nios_ii_pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nios_ii_pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for a
// stable lock with timeout/retry, then releases the system reset.
module nios_ii_pll_reset_ctrl
    import nios_ii_pll_ctrl_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_STABLE    = 256,
    parameter int MAX_RETRIES    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               soft_reset_req,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_reset_n,
    output logic               fail,
    output logic [STATE_W-1:0] state,
    output logic [LLC_W-1:0]   lock_loss_count
);

    localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic                 lock_s;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RTY_W-1:0]     retry_q, retry_d;
    logic [LLC_W-1:0]     llc_q, llc_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 sys_reset_n_q, sys_reset_n_d;
    logic                 fail_q, fail_d;

    nios_ii_pll_lock_sync u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RESET_PLL;
            cnt_q         <= '0;
            retry_q       <= '0;
            llc_q         <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            llc_q         <= llc_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            fail_q        <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        if (soft_reset_req) begin
            state_d = ST_RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TO_LAST) begin
                        if (retry_q == RTY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RESET_PLL;
                            retry_d = retry_q + RTY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s)               state_d = ST_WAIT_LOCK;
                    else if (cnt_q == STB_LAST) state_d = ST_RUN;
                    else                       cnt_d   = cnt_q + CNT_W'(1);
                end
                ST_RUN: begin
                    retry_d = '0;
                    if (!lock_s) begin
                        state_d = ST_RESET_PLL;
                        if (llc_q != {LLC_W{1'b1}}) llc_d = llc_q + LLC_W'(1);
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                end
            endcase
        end
        // A soft request restarts the PLL pulse even when already in RESET_PLL.
        if ((state_d != state_q) || soft_reset_req) cnt_d = '0;
    end

    always_comb begin
        pll_rst_d     = (state_d == ST_RESET_PLL);
        sys_reset_n_d = (state_d == ST_RUN);
        fail_d        = (state_d == ST_FAIL);
    end

    assign pll_rst         = pll_rst_q;
    assign sys_reset_n     = sys_reset_n_q;
    assign fail            = fail_q;
    assign state           = state_q;
    assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_nios_ii_pll_reset_ctrl.sv
// Directed bench for the PLL reset sequencer with small timing parameters.
module tb_nios_ii_pll_reset_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       soft_reset_req;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       fail;
    logic [2:0] state;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    nios_ii_pll_reset_ctrl #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .LOCK_STABLE    (8),
        .MAX_RETRIES    (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .soft_reset_req  (soft_reset_req),
        .pll_locked      (pll_locked),
        .pll_rst         (pll_rst),
        .sys_reset_n     (sys_reset_n),
        .fail            (fail),
        .state           (state),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},   32'(state),           32'd0);
        chk({tag, "_pll_rst"}, 32'(pll_rst),         32'd1);
        chk({tag, "_sysn"},    32'(sys_reset_n),     32'd0);
        chk({tag, "_fail"},    32'(fail),            32'd0);
        chk({tag, "_llc"},     32'(lock_loss_count), 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        soft_reset_req = 1'b0;
        pll_locked     = 1'b0;
        tick(2);
        chk_reset_vals("rst");

        // Power-up: release between edges, lock first sampled at edge 10
        reset_n = 1'b1;
        tick(3);
        chk("pu_e3_state",   32'(state),   32'd0);
        chk("pu_e3_pll_rst", 32'(pll_rst), 32'd1);
        tick(1);
        chk("pu_e4_state",   32'(state),   32'd1);
        chk("pu_e4_pll_rst", 32'(pll_rst), 32'd0);
        tick(5);
        pll_locked = 1'b1;
        tick(2);
        chk("pu_e11_state", 32'(state), 32'd1);
        tick(1);
        chk("pu_e12_state", 32'(state), 32'd2);
        tick(7);
        chk("pu_e19_state", 32'(state),       32'd2);
        chk("pu_e19_sysn",  32'(sys_reset_n), 32'd0);
        tick(1);
        chk("pu_e20_state", 32'(state),       32'd3);
        chk("pu_e20_sysn",  32'(sys_reset_n), 32'd1);
        chk("pu_llc",       32'(lock_loss_count), 32'd0);

        // Soft reset from RUN, then a 2-cycle lock glitch at STABLE count 5
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        chk("sr_state",   32'(state),           32'd0);
        chk("sr_pll_rst", 32'(pll_rst),         32'd1);
        chk("sr_llc",     32'(lock_loss_count), 32'd0);
        tick(4);
        chk("gl_wait",   32'(state), 32'd1);
        tick(1);
        chk("gl_stable", 32'(state), 32'd2);
        tick(5);
        pll_locked = 1'b0;
        tick(2);
        chk("gl_still_stable", 32'(state), 32'd2);
        pll_locked = 1'b1;
        tick(1);
        chk("gl_back_wait",  32'(state), 32'd1);
        tick(1);
        chk("gl_wait2",      32'(state), 32'd1);
        tick(1);
        chk("gl_restable",   32'(state), 32'd2);
        tick(7);
        chk("gl_pre_run_sysn", 32'(sys_reset_n), 32'd0);
        tick(1);
        chk("gl_run_state", 32'(state),       32'd3);
        chk("gl_run_sysn",  32'(sys_reset_n), 32'd1);

        // Lock loss coinciding with soft reset: no lock-loss count
        pll_locked = 1'b0;
        tick(2);
        chk("co_still_run", 32'(sys_reset_n), 32'd1);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        chk("co_state", 32'(state),           32'd0);
        chk("co_llc",   32'(lock_loss_count), 32'd0);

        // Lock loss in RUN
        pll_locked = 1'b1;
        wait_state("ll_reach_run", 3'd3, 100);
        pll_locked = 1'b0;
        tick(2);
        chk("ll_e2_sysn", 32'(sys_reset_n), 32'd1);
        tick(1);
        chk("ll_e3_sysn",    32'(sys_reset_n),     32'd0);
        chk("ll_e3_pll_rst", 32'(pll_rst),         32'd1);
        chk("ll_e3_state",   32'(state),           32'd0);
        chk("ll_e3_llc",     32'(lock_loss_count), 32'd1);

        // Saturation of the lock-loss counter
        for (int i = 0; i < 299; i++) begin
            pll_locked = 1'b1;
            wait_state("sat_reach_run", 3'd3, 100);
            pll_locked = 1'b0;
            tick(3);
            if (i == 252) chk("sat_254", 32'(lock_loss_count), 32'd254);
        end
        chk("sat_255",   32'(lock_loss_count), 32'd255);
        chk("sat_state", 32'(state),           32'd0);

        // Retry to FAIL with lock held low (RESET_PLL just entered)
        tick(4);
        chk("rt_wait1", 32'(state), 32'd1);
        tick(31);
        chk("rt_wait1_end", 32'(state), 32'd1);
        tick(1);
        chk("rt_rst2",         32'(state),   32'd0);
        chk("rt_rst2_pll_rst", 32'(pll_rst), 32'd1);
        tick(4);
        chk("rt_wait2", 32'(state), 32'd1);
        tick(32);
        chk("rt_rst3", 32'(state), 32'd0);
        tick(4);
        chk("rt_wait3", 32'(state), 32'd1);
        tick(31);
        chk("rt_wait3_fail", 32'(fail), 32'd0);
        tick(1);
        chk("rt_fail_state",   32'(state),       32'd4);
        chk("rt_fail_flag",    32'(fail),        32'd1);
        chk("rt_fail_sysn",    32'(sys_reset_n), 32'd0);
        chk("rt_fail_pll_rst", 32'(pll_rst),     32'd0);
        tick(5);
        chk("rt_fail_hold", 32'(state), 32'd4);
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        chk("rt_sr_state", 32'(state),           32'd0);
        chk("rt_sr_fail",  32'(fail),            32'd0);
        chk("rt_sr_llc",   32'(lock_loss_count), 32'd255);

        // Asynchronous reset while in STABLE, between clock edges
        pll_locked = 1'b1;
        wait_state("ar_reach_stable", 3'd2, 100);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        #1;
        reset_n = 1'b1;
        tick(3);
        chk("ar_e3_pll_rst", 32'(pll_rst), 32'd1);
        tick(1);
        chk("ar_e4_state", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_ii_pll_reset_ctrl.md
# nios_ii_pll_reset_ctrl

Reset sequencer and lock supervisor for the NIOS II system PLL: 50 MHz reference in, two 100 MHz outputs, active-high `rst` and `locked`. Runs on the free-running reference clock. Holds the PLL in reset for a minimum pulse, waits with a timeout for a stable lock, then releases the system reset. On timeout it retries; on loss of lock it re-sequences. Sits between the board reset and the PLL wrapper, and drives the system reset for all Qsys/NIOS logic.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: width of the `pll_rst` pulse in clk cycles (≥1).
- `LOCK_TIMEOUT`, 65536: max cycles in WAIT_LOCK before a retry.
- `LOCK_STABLE`, 256: consecutive synchronized-lock cycles required before release (≥1).
- `MAX_RETRIES`, 3: timeouts tolerated before FAIL.

Ports:
- `clk` in 1: 50 MHz reference clock, the same net as the PLL refclk.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `soft_reset_req` in 1: synchronous single-cycle request for a full re-sequence.
- `pll_locked` in 1: PLL `locked`, asynchronous to clk; synchronized internally.
- `pll_rst` out 1: active-high reset to the PLL `rst`.
- `sys_reset_n` out 1: active-low system reset.
- `fail` out 1: high while in FAIL.
- `state` out 3: current state encoding.
- `lock_loss_count` out 8: number of RUN→RESET_PLL lock losses; saturates at 255.

## Operation
- Reset values: state=RESET_PLL, pll_rst=1, sys_reset_n=0, fail=0, lock_loss_count=0. The cycle counter and retry counter reset to 0.
- `pll_locked` passes through a 2-FF synchronizer to give `lock_s`.
- One shared cycle counter, cleared on every state transition. Width = clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)).
- States and encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. Other encodings go to RESET_PLL.
- RESET_PLL: pll_rst=1. After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - If lock_s=1, go to STABLE.
  - If the counter reaches LOCK_TIMEOUT-1 with no lock and retry==MAX_RETRIES, go to FAIL.
  - Otherwise on that timeout, increment retry and go to RESET_PLL.
- STABLE: the counter increments while lock_s=1.
  - If lock_s=0, go to WAIT_LOCK. The timeout window restarts and retry is unchanged.
  - If the counter reaches LOCK_STABLE-1 with lock_s=1, go to RUN.
- RUN: sys_reset_n=1 and retry is cleared. If lock_s=0, increment lock_loss_count (saturating) and go to RESET_PLL.
- FAIL: pll_rst=0, sys_reset_n=0, fail=1. Exits only via `soft_reset_req` or `reset_n`.
- `soft_reset_req` in any state: go to RESET_PLL and clear retry. It does not increment lock_loss_count.
- Priority when events coincide: soft_reset_req first, then lock loss or timeout, then normal advance.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as `state`.

## Timing
- After reset_n deasserts, pll_rst stays high for exactly PLL_RST_CYCLES rising edges, then falls.
- Lock latency: pll_locked first sampled high at edge e gives lock_s=1 after edge e+1, STABLE at edge e+2, and sys_reset_n=1 at edge e+2+LOCK_STABLE.
- Lock loss in RUN: lock_s low at edge k gives sys_reset_n=0 and pll_rst=1 at edge k+1. Worst-case detection is 3 cycles after the pll_locked fall.
- Timeout: WAIT_LOCK entered at edge w with no lock gives RESET_PLL (or FAIL) at edge w+LOCK_TIMEOUT.
- sys_reset_n asserts asynchronously on reset_n low and always deasserts synchronously to clk.
- A lock glitch shorter than 1 cycle may be missed. A glitch that is sampled restarts STABLE.

## Structure
- Package `nios_ii_pll_ctrl_pkg` holds the state encodings (width 3) and the lock_loss_count width (8).
- One sub-module, `nios_ii_pll_lock_sync`: a 2-FF synchronizer with async active-low reset to 0.
- The FSM, counters and output registers live in the top module.

## Test plan
Parameters for all tests: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRIES=2.
- Power-up: release reset_n, raise pll_locked at edge 10 → pll_rst high for edges 1–4, state walks 0→1→2→3, sys_reset_n rises at edge 20.
- Lock glitch in STABLE: drop pll_locked for 2 cycles at STABLE count 5 → returns to WAIT_LOCK and then re-enters STABLE. sys_reset_n rises only after 8 clean cycles.
- Retry to FAIL: hold pll_locked=0 → three RESET_PLL pulses (initial + 2 retries), then FAIL after the third timeout with fail=1 and sys_reset_n=0. A soft_reset_req pulse then gives state=0, fail=0.
- Lock loss in RUN: drop pll_locked → sys_reset_n=0 at most 3 edges later and lock_loss_count=1. Repeat 300 times → count saturates at 255.
- Coincident events: in RUN, drop lock and pulse soft_reset_req on the same edge → RESET_PLL and lock_loss_count unchanged.
- Mid-operation async reset: assert reset_n in STABLE between edges → outputs immediately at reset values with no clk edge needed.
